mem_rr_arbiter: RTL

//  Round-robin arbiter sharing one memory-bus master port between NPORTS requesters (e.g. IF/LSU/debug).

---
 rtl/mem_rr_arbiter_if.sv | 38 +++
 rtl/mem_rr_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mem_rr_arbiter_if.sv
// Bus bundle for mem_rr_arbiter: the bundled requester ports plus the single shared memory master port.
// The slave modport is the arbiter's view; the master modport is the environment (requesters and memory).
interface mem_rr_arbiter_if #(
    parameter int NPORTS = 2,
    parameter int ADDRW  = 32,
    parameter int DATAW  = 32,
    parameter int MASKW  = DATAW / 8
);
    logic [NPORTS-1:0]       stall_o;
    logic [NPORTS*ADDRW-1:0] slave_addr_i;
    logic [NPORTS*DATAW-1:0] slave_rdata_o;
    logic [NPORTS*DATAW-1:0] slave_wdata_i;
    logic [NPORTS*MASKW-1:0] slave_mask_i;
    logic [NPORTS-1:0]       slave_we_i;
    logic [NPORTS-1:0]       slave_valid_i;
    logic [NPORTS-1:0]       slave_resp_o;
    logic [ADDRW-1:0]        master_addr_o;
    logic [DATAW-1:0]        master_rdata_i;
    logic [DATAW-1:0]        master_wdata_o;
    logic [MASKW-1:0]        master_mask_o;
    logic                    master_we_o;
    logic                    master_valid_o;
    logic                    master_resp_i;

    modport slave (
        output stall_o, slave_rdata_o, slave_resp_o,
        output master_addr_o, master_wdata_o, master_mask_o, master_we_o, master_valid_o,
        input  slave_addr_i, slave_wdata_i, slave_mask_i, slave_we_i, slave_valid_i,
        input  master_rdata_i, master_resp_i
    );

    modport master (
        input  stall_o, slave_rdata_o, slave_resp_o,
        input  master_addr_o, master_wdata_o, master_mask_o, master_we_o, master_valid_o,
        output slave_addr_i, slave_wdata_i, slave_mask_i, slave_we_i, slave_valid_i,
        output master_rdata_i, master_resp_i
    );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one memory master port among NPORTS requesters.
// Grant and master-side request are registered; one transaction outstanding at a time.
module mem_rr_arbiter #(
    parameter int NPORTS = 2,
    parameter int ADDRW  = 32,
    parameter int DATAW  = 32,
    parameter int MASKW  = DATAW / 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    mem_rr_arbiter_if.slave  bus
);
    localparam int GW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [GW-1:0]           grant_q, grant_d;
    logic [ADDRW-1:0]        master_addr_q, master_addr_d;
    logic [DATAW-1:0]        master_wdata_q, master_wdata_d;
    logic [MASKW-1:0]        master_mask_q, master_mask_d;
    logic                    master_we_q, master_we_d;
    logic                    master_valid_q, master_valid_d;
    logic [NPORTS*DATAW-1:0] slave_rdata_q, slave_rdata_d;
    logic [NPORTS-1:0]       slave_resp_q, slave_resp_d;

    logic [GW-1:0]           pick_hi, pick_lo, pick;
    logic                    pick_hi_vld, pick_lo_vld, pick_vld;
    logic [NPORTS-1:0]       stall;

    // Rotating priority: first requester strictly above the last grant, else the lowest one at or below it.
    always_comb begin
        pick_hi     = '0;
        pick_lo     = '0;
        pick_hi_vld = 1'b0;
        pick_lo_vld = 1'b0;
        for (int p = 0; p < NPORTS; p++) begin
            if (bus.slave_valid_i[p]) begin
                if (GW'(p) > grant_q) begin
                    if (!pick_hi_vld) begin
                        pick_hi     = GW'(p);
                        pick_hi_vld = 1'b1;
                    end
                end else if (!pick_lo_vld) begin
                    pick_lo     = GW'(p);
                    pick_lo_vld = 1'b1;
                end
            end
        end
        pick     = pick_hi_vld ? pick_hi : pick_lo;
        pick_vld = pick_hi_vld | pick_lo_vld;
    end

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        master_addr_d  = master_addr_q;
        master_wdata_d = master_wdata_q;
        master_mask_d  = master_mask_q;
        master_we_d    = master_we_q;
        master_valid_d = master_valid_q;
        slave_rdata_d  = slave_rdata_q;
        slave_resp_d   = '0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d        = pick;
                    master_addr_d  = bus.slave_addr_i[pick*ADDRW +: ADDRW];
                    master_wdata_d = bus.slave_wdata_i[pick*DATAW +: DATAW];
                    master_mask_d  = bus.slave_mask_i[pick*MASKW +: MASKW];
                    master_we_d    = bus.slave_we_i[pick];
                    master_valid_d = 1'b1;
                    state_d        = BUSY;
                end
            end
            BUSY: begin
                if (bus.master_resp_i) begin
                    master_valid_d = 1'b0;
                    slave_rdata_d  = {NPORTS{bus.master_rdata_i}};
                    for (int p = 0; p < NPORTS; p++) begin
                        slave_resp_d[p] = (grant_q == GW'(p));
                    end
                    state_d = DONE;
                end
            end
            // One dead cycle lets the requester drop or replace valid before re-arbitration.
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            grant_q        <= GW'(NPORTS - 1);
            master_addr_q  <= '0;
            master_wdata_q <= '0;
            master_mask_q  <= '0;
            master_we_q    <= 1'b0;
            master_valid_q <= 1'b0;
            slave_rdata_q  <= '0;
            slave_resp_q   <= '0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            master_addr_q  <= master_addr_d;
            master_wdata_q <= master_wdata_d;
            master_mask_q  <= master_mask_d;
            master_we_q    <= master_we_d;
            master_valid_q <= master_valid_d;
            slave_rdata_q  <= slave_rdata_d;
            slave_resp_q   <= slave_resp_d;
        end
    end

    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_stall
        assign stall[gi] = bus.slave_valid_i[gi] & ~((state_q != IDLE) && (grant_q == GW'(gi)));
    end

    assign bus.stall_o        = stall;
    assign bus.slave_rdata_o  = slave_rdata_q;
    assign bus.slave_resp_o   = slave_resp_q;
    assign bus.master_addr_o  = master_addr_q;
    assign bus.master_wdata_o = master_wdata_q;
    assign bus.master_mask_o  = master_mask_q;
    assign bus.master_we_o    = master_we_q;
    assign bus.master_valid_o = master_valid_q;
endmodule
